// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Define BP_STATS_EN to add the BP_lookups / BP_mispredicts statistics counters.
module branch_predictor #(
  parameter int PC_BITS  = 12,
  parameter int IDX_BITS = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_BITS-1:0] F_pc,
  output logic               F_BP_taken,
  output logic [PC_BITS-1:0] F_BP_target_pc,
  input  logic               EX_upd_en,
  input  logic [PC_BITS-1:0] EX_pc,
  input  logic               EX_true_taken,
  input  logic [PC_BITS-1:0] EX_target_pc
`ifdef BP_STATS_EN
  ,
  output logic [31:0]        BP_lookups,
  output logic [31:0]        BP_mispredicts
`endif
);

  localparam int ENTRIES  = 1 << IDX_BITS;
  localparam int TAG_BITS = PC_BITS - IDX_BITS;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [PC_BITS-1:0]  target;
    logic [1:0]          ctr;
  } entry_t;

  localparam entry_t RST_ENTRY = '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};

  entry_t [ENTRIES-1:0] tbl_q, tbl_d;

  logic [IDX_BITS-1:0] f_idx, ex_idx;
  logic [TAG_BITS-1:0] f_tag, ex_tag;
  logic                f_hit, ex_hit, ex_pred;

  assign f_idx  = F_pc[IDX_BITS-1:0];
  assign f_tag  = F_pc[PC_BITS-1:IDX_BITS];
  assign ex_idx = EX_pc[IDX_BITS-1:0];
  assign ex_tag = EX_pc[PC_BITS-1:IDX_BITS];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign f_hit          = tbl_q[f_idx].valid && (tbl_q[f_idx].tag == f_tag);
  assign F_BP_taken     = f_hit && tbl_q[f_idx].ctr[1];
  assign F_BP_target_pc = F_BP_taken ? tbl_q[f_idx].target : '0;

  assign ex_hit  = tbl_q[ex_idx].valid && (tbl_q[ex_idx].tag == ex_tag);
  assign ex_pred = ex_hit && tbl_q[ex_idx].ctr[1];

  always_comb begin
    tbl_d = tbl_q;
    if (EX_upd_en) begin
      if (ex_hit) begin
        if (EX_true_taken) begin
          if (tbl_q[ex_idx].ctr != 2'b11) tbl_d[ex_idx].ctr = tbl_q[ex_idx].ctr + 2'b01;
          tbl_d[ex_idx].target = EX_target_pc;
        end else if (tbl_q[ex_idx].ctr != 2'b00) begin
          tbl_d[ex_idx].ctr = tbl_q[ex_idx].ctr - 2'b01;
        end
      end else if (EX_true_taken) begin
        // Not-taken misses never allocate; taken misses evict whatever lived here.
        tbl_d[ex_idx] = '{valid: 1'b1, tag: ex_tag, target: EX_target_pc, ctr: 2'b10};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) tbl_q[i] <= RST_ENTRY;
    end else begin
      tbl_q <= tbl_d;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] lookups_q, lookups_d, mispredicts_q, mispredicts_d;

  always_comb begin
    lookups_d     = lookups_q;
    mispredicts_d = mispredicts_q;
    if (EX_upd_en) begin
      if (lookups_q != 32'hFFFF_FFFF) lookups_d = lookups_q + 32'd1;
      if ((ex_pred != EX_true_taken) && (mispredicts_q != 32'hFFFF_FFFF))
        mispredicts_d = mispredicts_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lookups_q     <= '0;
      mispredicts_q <= '0;
    end else begin
      lookups_q     <= lookups_d;
      mispredicts_q <= mispredicts_d;
    end
  end

  assign BP_lookups     = lookups_q;
  assign BP_mispredicts = mispredicts_q;
`else
  logic unused_ex_pred;
  assign unused_ex_pred = ex_pred;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// Randomized and directed bench for branch_predictor against a table model kept
// as plain integer arrays indexed by pc % entries.
module tb_branch_predictor;
  localparam int PC_BITS  = 12;
  localparam int IDX_BITS = 4;
  localparam int N        = 1 << IDX_BITS;

  logic               clk = 1'b0;
  logic               rst;
  logic [PC_BITS-1:0] F_pc;
  logic               F_BP_taken;
  logic [PC_BITS-1:0] F_BP_target_pc;
  logic               EX_upd_en;
  logic [PC_BITS-1:0] EX_pc;
  logic               EX_true_taken;
  logic [PC_BITS-1:0] EX_target_pc;
`ifdef BP_STATS_EN
  logic [31:0]        BP_lookups, BP_mispredicts;
`endif

  branch_predictor #(.PC_BITS(PC_BITS), .IDX_BITS(IDX_BITS)) dut (
    .clk(clk), .rst(rst), .F_pc(F_pc), .F_BP_taken(F_BP_taken),
    .F_BP_target_pc(F_BP_target_pc), .EX_upd_en(EX_upd_en), .EX_pc(EX_pc),
    .EX_true_taken(EX_true_taken), .EX_target_pc(EX_target_pc)
`ifdef BP_STATS_EN
    , .BP_lookups(BP_lookups), .BP_mispredicts(BP_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: one slot per index holding owner tag, target and counter value 0..3.
  bit     m_valid [N];
  int     m_tag   [N];
  int     m_tgt   [N];
  int     m_ctr   [N];
  longint m_lookups, m_mis;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_lookups = 0; m_mis = 0;
  endtask

  function automatic bit model_hit(int pc);
    return m_valid[pc % N] && (m_tag[pc % N] == pc / N);
  endfunction

  function automatic bit model_taken(int pc);
    return model_hit(pc) && (m_ctr[pc % N] >= 2);
  endfunction

  function automatic int model_target(int pc);
    return model_taken(pc) ? m_tgt[pc % N] : 0;
  endfunction

  task automatic model_update(int pc, bit tk, int tgt);
    int i;
    i = pc % N;
    if (m_lookups < 64'hFFFF_FFFF) m_lookups++;
    if (model_taken(pc) != tk && m_mis < 64'hFFFF_FFFF) m_mis++;
    if (model_hit(pc)) begin
      if (tk) begin
        m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
        m_tgt[i] = tgt;
      end else begin
        m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
      end
    end else if (tk) begin
      m_valid[i] = 1; m_tag[i] = pc / N; m_tgt[i] = tgt; m_ctr[i] = 2;
    end
  endtask

  // Advance one clock; the model takes the same edge the DUT does.
  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else if (EX_upd_en) model_update(int'(EX_pc), EX_true_taken, int'(EX_target_pc));
    #1;
  endtask

  task automatic set_upd(bit en, int pc, bit tk, int tgt);
    EX_upd_en = en; EX_pc = PC_BITS'(pc); EX_true_taken = tk; EX_target_pc = PC_BITS'(tgt);
  endtask

  task automatic do_reset();
    rst = 1'b1; set_upd(0, 0, 0, 0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic upd_cycle(int pc, bit tk, int tgt);
    set_upd(1, pc, tk, tgt);
    tick();
    set_upd(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    F_pc = 12'h034; #1;
    total++; if (F_BP_taken !== 1'b0) begin bad++; $display("FAIL reset_taken got=%b exp=0", F_BP_taken); end
    total++; if (F_BP_target_pc !== 12'h000) begin bad++; $display("FAIL reset_target got=%h exp=000", F_BP_target_pc); end
    for (int k = 0; k < 4; k++) begin
      F_pc = PC_BITS'($urandom); #1;
      total++;
      if (F_BP_taken !== 1'b0 || F_BP_target_pc !== 12'h000) begin
        bad++; $display("FAIL reset_sweep pc=%h got=%b/%h exp=0/000", F_pc, F_BP_taken, F_BP_target_pc);
      end
    end
`ifdef BP_STATS_EN
    total++; if (BP_lookups !== 32'd0 || BP_mispredicts !== 32'd0) begin
      bad++; $display("FAIL reset_stats got=%0d/%0d exp=0/0", BP_lookups, BP_mispredicts);
    end
`endif
  endtask

  task automatic test_alloc();
    do_reset();
    upd_cycle(12'h034, 1, 12'h100);
    F_pc = 12'h034; #1;
    total++; if (F_BP_taken !== 1'b1 || F_BP_target_pc !== 12'h100) begin
      bad++; $display("FAIL alloc_hit got=%b/%h exp=1/100", F_BP_taken, F_BP_target_pc);
    end
    F_pc = 12'h044; #1;
    total++; if (F_BP_taken !== 1'b0 || F_BP_target_pc !== 12'h000) begin
      bad++; $display("FAIL alias_miss got=%b/%h exp=0/000", F_BP_taken, F_BP_target_pc);
    end
    upd_cycle(12'h044, 0, 12'h000);
    F_pc = 12'h034; #1;
    total++; if (F_BP_taken !== 1'b1) begin bad++; $display("FAIL nt_miss_no_alloc got=%b exp=1", F_BP_taken); end
  endtask

  task automatic test_decrement();
    do_reset();
    upd_cycle(12'h034, 1, 12'h100);
    upd_cycle(12'h034, 0, 12'h000);
    F_pc = 12'h034; #1;
    total++; if (F_BP_taken !== 1'b0 || F_BP_target_pc !== 12'h000) begin
      bad++; $display("FAIL dec_first got=%b/%h exp=0/000", F_BP_taken, F_BP_target_pc);
    end
    upd_cycle(12'h034, 0, 12'h000);
    upd_cycle(12'h034, 0, 12'h000);
    // Counter sits at 00: one taken lands at 01 (still not taken), a second at 10.
    upd_cycle(12'h034, 1, 12'h150);
    #1;
    total++; if (F_BP_taken !== 1'b0) begin bad++; $display("FAIL dec_floor got=%b exp=0", F_BP_taken); end
    upd_cycle(12'h034, 1, 12'h150);
    #1;
    total++; if (F_BP_taken !== 1'b1 || F_BP_target_pc !== 12'h150) begin
      bad++; $display("FAIL dec_recover got=%b/%h exp=1/150", F_BP_taken, F_BP_target_pc);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    upd_cycle(12'h034, 1, 12'h100);
    upd_cycle(12'h034, 1, 12'h100);
    upd_cycle(12'h034, 1, 12'h120);
    F_pc = 12'h034; #1;
    total++; if (F_BP_taken !== 1'b1 || F_BP_target_pc !== 12'h120) begin
      bad++; $display("FAIL sat_target got=%b/%h exp=1/120", F_BP_taken, F_BP_target_pc);
    end
    upd_cycle(12'h034, 0, 12'h000);
    #1;
    total++; if (F_BP_taken !== 1'b1 || F_BP_target_pc !== 12'h120) begin
      bad++; $display("FAIL sat_one_nt got=%b/%h exp=1/120", F_BP_taken, F_BP_target_pc);
    end
    upd_cycle(12'h034, 0, 12'h000);
    #1;
    total++; if (F_BP_taken !== 1'b0) begin bad++; $display("FAIL sat_two_nt got=%b exp=0", F_BP_taken); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_upd(1, 12'h034, 1, 12'h200);
    F_pc = 12'h034; #1;
    total++; if (F_BP_taken !== 1'b0 || F_BP_target_pc !== 12'h000) begin
      bad++; $display("FAIL same_cycle_pre got=%b/%h exp=0/000", F_BP_taken, F_BP_target_pc);
    end
    tick();
    set_upd(0, 0, 0, 0); #1;
    total++; if (F_BP_taken !== 1'b1 || F_BP_target_pc !== 12'h200) begin
      bad++; $display("FAIL same_cycle_post got=%b/%h exp=1/200", F_BP_taken, F_BP_target_pc);
    end
  endtask

  task automatic test_reset_with_update();
    do_reset();
    upd_cycle(12'h034, 1, 12'h100);
    upd_cycle(12'h0a7, 1, 12'h333);
    rst = 1'b1;
    set_upd(1, 12'h034, 1, 12'h300);
    tick();
    rst = 1'b0;
    set_upd(0, 0, 0, 0);
    F_pc = 12'h034; #1;
    total++; if (F_BP_taken !== 1'b0 || F_BP_target_pc !== 12'h000) begin
      bad++; $display("FAIL rst_upd_034 got=%b/%h exp=0/000", F_BP_taken, F_BP_target_pc);
    end
    F_pc = 12'h0a7; #1;
    total++; if (F_BP_taken !== 1'b0) begin bad++; $display("FAIL rst_forget_0a7 got=%b exp=0", F_BP_taken); end
`ifdef BP_STATS_EN
    total++; if (BP_lookups !== 32'd0 || BP_mispredicts !== 32'd0) begin
      bad++; $display("FAIL rst_upd_stats got=%0d/%0d exp=0/0", BP_lookups, BP_mispredicts);
    end
`endif
  endtask

  task automatic test_random();
    int pc, exp_tgt;
    bit exp_tk;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 59) == 0);
      pc  = $urandom_range(0, 3) * N + $urandom_range(0, N - 1);
      set_upd($urandom_range(0, 3) != 0, pc, $urandom_range(0, 2) != 0, $urandom_range(0, 4095));
      F_pc = ($urandom_range(0, 1) == 1) ? EX_pc : PC_BITS'($urandom_range(0, 3) * N + $urandom_range(0, N - 1));
      #1;
      exp_tk  = model_taken(int'(F_pc));
      exp_tgt = model_target(int'(F_pc));
      total++;
      if (F_BP_taken !== exp_tk || int'(F_BP_target_pc) !== exp_tgt) begin
        bad++; $display("FAIL rand_lookup n=%0d pc=%h got=%b/%h exp=%b/%h",
                        n, F_pc, F_BP_taken, F_BP_target_pc, exp_tk, exp_tgt);
      end
`ifdef BP_STATS_EN
      total++;
      if (longint'(BP_lookups) != m_lookups || longint'(BP_mispredicts) != m_mis) begin
        bad++; $display("FAIL rand_stats n=%0d got=%0d/%0d exp=%0d/%0d",
                        n, BP_lookups, BP_mispredicts, m_lookups, m_mis);
      end
`endif
      tick();
    end
    rst = 1'b0;
    set_upd(0, 0, 0, 0);
  endtask

  initial begin
    rst = 1'b1; F_pc = '0;
    set_upd(0, 0, 0, 0);
    model_reset();
    test_reset();
    test_alloc();
    test_decrement();
    test_saturate();
    test_same_cycle();
    test_reset_with_update();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
